// File: rtl/vmicro16_reset_seq.sv
// vmicro16_reset_seq
// Reset sequencer for multi-core vmicro16 SoC builds. The external pin reset
// is synchronised, every domain is held for HOLD_CYCLES, then the peripheral
// domain and each core are released in order, STAGGER cycles apart.
// A system soft reset restarts the whole sequence. Per-core soft resets hold
// one core for HOLD_CYCLES while the rest of the SoC keeps running.
// rst_cause records what started the most recent full sequence.
//
// Request signalling: soft_req and core_rst_req are level inputs sampled on
// every rising clk edge; there is no handshake or acknowledge. A request held
// high is simply seen again on every edge it stays high.
//
// All outputs come straight from flops. The only input-to-output path is the
// asynchronous assertion of the pin reset.
//
// fsm_state is a debug view of the sequencer state:
//   0 = ASSERT, 1 = RELEASE, 2 = RUN.
module vmicro16_reset_seq #(
    parameter int N_CORES     = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGGER     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               soft_req,
    input  logic [N_CORES-1:0] core_rst_req,
    output logic               periph_reset,
    output logic [N_CORES-1:0] core_reset,
    output logic               ready,
    output logic [1:0]         rst_cause,
    output logic [1:0]         fsm_state
);

    // The main counter covers both the hold phase and the full release span.
    localparam int REL_SPAN = N_CORES * STAGGER;
    localparam int CNT_MAX  = (HOLD_CYCLES > REL_SPAN) ? HOLD_CYCLES : REL_SPAN;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int PW       = $clog2(HOLD_CYCLES + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'(REL_SPAN - 1);
    localparam logic [PW-1:0] PCNT_LOAD = PW'(HOLD_CYCLES);
    localparam logic [PW-1:0] PCNT_ONE  = PW'(1);

    localparam logic [1:0] CAUSE_PIN  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Synchroniser: all ones while the pin is low, then zeros shift through.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_s;

    // Current register state.
    state_t                      state_q;
    logic [CW-1:0]               cnt_q;
    logic                        periph_q;
    logic [N_CORES-1:0]          core_q;
    logic                        ready_q;
    logic [1:0]                  cause_q;
    logic [N_CORES-1:0][PW-1:0]  pcnt_q;

    // Next-state values.
    state_t                      state_d;
    logic [CW-1:0]               cnt_d;
    logic                        periph_d;
    logic [N_CORES-1:0]          core_d;
    logic                        ready_d;
    logic [1:0]                  cause_d;
    logic [N_CORES-1:0][PW-1:0]  pcnt_d;

    // Reset synchroniser: assertion is immediate, release takes SYNC_STAGES edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_s = sync_q[SYNC_STAGES-1];

    // Next-state and output logic for the sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        core_d   = core_q;
        ready_d  = ready_q;
        cause_d  = cause_q;
        pcnt_d   = pcnt_q;

        // Nothing advances until the synchronised reset has been released.
        if (!rst_s) begin
            if (soft_req) begin
                // Soft reset outranks everything, including per-core requests.
                state_d  = ST_ASSERT;
                cnt_d    = '0;
                periph_d = 1'b1;
                core_d   = '1;
                ready_d  = 1'b0;
                cause_d  = CAUSE_SOFT;
                pcnt_d   = '0;
            end else begin
                case (state_q)
                    ST_ASSERT: begin
                        if (cnt_q == HOLD_LAST) begin
                            periph_d = 1'b0;
                            state_d  = ST_RELEASE;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end

                    ST_RELEASE: begin
                        cnt_d = cnt_q + 1'b1;
                        // Core i drops (i+1)*STAGGER edges after the peripheral domain.
                        for (int i = 0; i < N_CORES; i++) begin
                            if (cnt_q == CW'((i + 1) * STAGGER - 1)) begin
                                core_d[i] = 1'b0;
                            end
                        end
                        if (cnt_q == REL_LAST) begin
                            ready_d = 1'b1;
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end
                    end

                    ST_RUN: begin
                        // Per-core holds: a request (re)loads the counter, the
                        // core drops on the edge the counter would reach zero.
                        for (int i = 0; i < N_CORES; i++) begin
                            if (core_rst_req[i]) begin
                                core_d[i] = 1'b1;
                                pcnt_d[i] = PCNT_LOAD;
                            end else if (pcnt_q[i] == PCNT_ONE) begin
                                core_d[i] = 1'b0;
                                pcnt_d[i] = '0;
                            end else if (pcnt_q[i] != '0) begin
                                pcnt_d[i] = pcnt_q[i] - 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_d = ST_ASSERT;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    // Sequencer registers; the pin reset returns everything to the power-on state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_ASSERT;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            core_q   <= '1;
            ready_q  <= 1'b0;
            cause_q  <= CAUSE_PIN;
            pcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            ready_q  <= ready_d;
            cause_q  <= cause_d;
            pcnt_q   <= pcnt_d;
        end
    end

    assign periph_reset = periph_q;
    assign core_reset   = core_q;
    assign ready        = ready_q;
    assign rst_cause    = cause_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_vmicro16_reset_seq.sv
// Bench for vmicro16_reset_seq: default build (dut_a) and a swept build (dut_b,
// 4 cores, HOLD 1, STAGGER 1, SYNC 3). Expected output vectors are packed as
// {periph_reset, core_reset, ready, rst_cause} in the low bits of a byte.
module tb_vmicro16_reset_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, soft_a;
    logic [1:0] creq_a;
    logic       periph_a, ready_a;
    logic [1:0] core_a, cause_a, state_a;

    logic       reset_b, soft_b;
    logic [3:0] creq_b;
    logic       periph_b, ready_b;
    logic [3:0] core_b;
    logic [1:0] cause_b, state_b;

    logic [7:0] obs_a, obs_b;
    assign obs_a = {2'b00, periph_a, core_a, ready_a, cause_a};
    assign obs_b = {periph_b, core_b, ready_b, cause_b};

    vmicro16_reset_seq dut_a (
        .clk          (clk),
        .reset        (reset_a),
        .soft_req     (soft_a),
        .core_rst_req (creq_a),
        .periph_reset (periph_a),
        .core_reset   (core_a),
        .ready        (ready_a),
        .rst_cause    (cause_a),
        .fsm_state    (state_a)
    );

    vmicro16_reset_seq #(
        .N_CORES     (4),
        .HOLD_CYCLES (1),
        .STAGGER     (1),
        .SYNC_STAGES (3)
    ) dut_b (
        .clk          (clk),
        .reset        (reset_b),
        .soft_req     (soft_b),
        .core_rst_req (creq_b),
        .periph_reset (periph_b),
        .core_reset   (core_b),
        .ready        (ready_b),
        .rst_cause    (cause_b),
        .fsm_state    (state_b)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    string      tag_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    localparam logic [1:0] PIN  = 2'b01;
    localparam logic [1:0] SOFT = 2'b10;

    // Timeline model: d = edges after the reference edge (rst_s fall or soft edge).
    function automatic logic [7:0] tl_exp(input int d, input int n, input int hold,
                                          input int stag, input logic [1:0] cause);
        logic [7:0] v;
        v      = '0;
        v[1:0] = cause;
        v[2]   = (d >= hold + n * stag);
        for (int i = 0; i < n; i++) v[3 + i] = (d < hold + (i + 1) * stag);
        v[3 + n] = (d < hold);
        return v;
    endfunction

    function automatic logic [7:0] pack_a(input logic p, input logic [1:0] c,
                                          input logic r, input logic [1:0] cause);
        return {2'b00, p, c, r, cause};
    endfunction

    task automatic expect_val(input logic [7:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic check_obs(input logic [7:0] obs);
        logic [7:0] e;
        string      t;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %b required an expected entry", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", t, obs, e);
            end
        end
    endtask

    task automatic check_state(input logic [1:0] obs, input logic [1:0] e, input string t);
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_a(input logic [7:0] e, input string t);
        expect_val(e, t);
        tick();
        check_obs(obs_a);
    endtask

    task automatic step_b(input logic [7:0] e, input string t);
        expect_val(e, t);
        tick();
        check_obs(obs_b);
    endtask

    // Release the pin of dut_a and follow the power-on timeline for 12 edges.
    task automatic por_a(input string t);
        reset_a = 1'b1;
        for (int e = 0; e < 12; e++)
            step_a(tl_exp(e - 1, 2, 4, 2, PIN), $sformatf("%s_e%0d", t, e));
    endtask

    // Guard against a hung run.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset_a = 1'b0; soft_a = 1'b0; creq_a = '0;
        reset_b = 1'b0; soft_b = 1'b0; creq_b = '0;
        repeat (3) tick();

        // Reset state of both builds.
        expect_val(pack_a(1'b1, 2'b11, 1'b0, PIN), "rst_state_a");
        check_obs(obs_a);
        expect_val(8'b1_1111_0_01, "rst_state_b");
        check_obs(obs_b);
        check_state(state_a, 2'd0, "rst_fsm_a");

        // Power-on timeline: periph E5, core0 E7, core1 + ready E9.
        por_a("por");
        check_state(state_a, 2'd2, "run_fsm_a");

        // Async pin assertion mid-cycle with no clock edge.
        #3 reset_a = 1'b0;
        #1;
        expect_val(pack_a(1'b1, 2'b11, 1'b0, PIN), "async_assert");
        check_obs(obs_a);
        step_a(pack_a(1'b1, 2'b11, 1'b0, PIN), "async_held");
        por_a("repor");

        // One-cycle soft reset pulse in RUN.
        soft_a = 1'b1;
        step_a(tl_exp(0, 2, 4, 2, SOFT), "soft_d0");
        soft_a = 1'b0;
        for (int d = 1; d < 10; d++)
            step_a(tl_exp(d, 2, 4, 2, SOFT), $sformatf("soft_d%0d", d));

        // Held soft request parks the sequencer in ASSERT.
        soft_a = 1'b1;
        for (int k = 0; k < 3; k++)
            step_a(tl_exp(0, 2, 4, 2, SOFT), $sformatf("softhold_k%0d", k));
        soft_a = 1'b0;
        for (int d = 1; d < 10; d++)
            step_a(tl_exp(d, 2, 4, 2, SOFT), $sformatf("softhold_d%0d", d));

        // Per-core reset of core 0: high C..C+3, low at C+4.
        creq_a = 2'b01;
        step_a(pack_a(1'b0, 2'b01, 1'b1, SOFT), "core0_c0");
        creq_a = 2'b00;
        for (int k = 1; k < 4; k++)
            step_a(pack_a(1'b0, 2'b01, 1'b1, SOFT), $sformatf("core0_c%0d", k));
        step_a(pack_a(1'b0, 2'b00, 1'b1, SOFT), "core0_c4");

        // Re-request at C+2 extends the hold: low at C+6.
        creq_a = 2'b01;
        step_a(pack_a(1'b0, 2'b01, 1'b1, SOFT), "rereq_c0");
        creq_a = 2'b00;
        step_a(pack_a(1'b0, 2'b01, 1'b1, SOFT), "rereq_c1");
        creq_a = 2'b01;
        step_a(pack_a(1'b0, 2'b01, 1'b1, SOFT), "rereq_c2");
        creq_a = 2'b00;
        for (int k = 3; k < 6; k++)
            step_a(pack_a(1'b0, 2'b01, 1'b1, SOFT), $sformatf("rereq_c%0d", k));
        step_a(pack_a(1'b0, 2'b00, 1'b1, SOFT), "rereq_c6");
        step_a(pack_a(1'b0, 2'b00, 1'b1, SOFT), "rereq_c7");

        // Soft and core request together: soft wins; core requests during RELEASE ignored.
        soft_a = 1'b1;
        creq_a = 2'b10;
        step_a(tl_exp(0, 2, 4, 2, SOFT), "prio_d0");
        soft_a = 1'b0;
        creq_a = 2'b00;
        for (int d = 1; d < 12; d++) begin
            if (d == 5) creq_a = 2'b11;
            if (d == 8) creq_a = 2'b00;
            step_a(tl_exp(d, 2, 4, 2, SOFT), $sformatf("prio_d%0d", d));
        end

        // A later pin reset brings the cause back to pin.
        #3 reset_a = 1'b0;
        #1;
        expect_val(pack_a(1'b1, 2'b11, 1'b0, PIN), "pin_after_soft");
        check_obs(obs_a);
        tick();

        // Swept build: rst_s low at E2, periph E3, cores E4..E7, ready E7.
        reset_b = 1'b1;
        for (int e = 0; e < 10; e++)
            step_b(tl_exp(e - 2, 4, 1, 1, PIN), $sformatf("sweep_e%0d", e));
        check_state(state_b, 2'd2, "run_fsm_b");

        // HOLD_CYCLES=1 per-core reset lasts exactly one cycle.
        creq_b = 4'b0100;
        step_b(8'b0_0100_1_01, "sweep_core2_c0");
        creq_b = 4'b0000;
        step_b(8'b0_0000_1_01, "sweep_core2_c1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vmicro16_reset_seq.md
Name: vmicro16_reset_seq

Overview:
Parametrised reset sequencer for multi-core vmicro16 SoC builds; replaces fixed "hold reset N clocks then release" sequencing with a synthesisable block.
Synchronises the external async active-low reset, holds all domains for a programmable count, then releases the peripheral domain followed by each core in staggered order.
Supports a system soft-reset request and independent per-core soft resets, and records the last reset cause.
Sits between the board reset pin and the SoC top; drives the active-high synchronous resets consumed by cores and peripherals.

Parameters:
N_CORES, 2, number of core reset channels (1..16)
HOLD_CYCLES, 4, cycles all resets stay asserted after synchronised reset release (>=1)
STAGGER, 2, cycles between successive domain releases (>=1)
SYNC_STAGES, 2, reset synchroniser depth (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low external reset; assertion immediate, deassertion synchronised internally
soft_req  in  1  system soft-reset request, sampled each clk
core_rst_req  in  N_CORES  per-core soft-reset requests, sampled each clk
periph_reset  out  1  active-high peripheral/interconnect reset
core_reset  out  N_CORES  active-high per-core resets
ready  out  1  high once the full release sequence has completed
rst_cause  out  2  01 = pin reset, 10 = soft reset, 00/11 unused

Behaviour:
- reset low: asynchronously force periph_reset=1, core_reset=all 1s, ready=0, rst_cause=01, FSM=ASSERT, all counters 0, synchroniser chain all 1s.
- Synchroniser: chain shifts in 0 each edge once reset is high; rst_s goes low on the SYNC_STAGES-th rising edge after reset rises.
- FSM states: ASSERT, RELEASE, RUN.
- ASSERT: entered with counter=0; counter increments each edge while rst_s=0; on the edge where counter==HOLD_CYCLES-1, periph_reset<=0, FSM<=RELEASE, counter<=0. periph_reset therefore falls HOLD_CYCLES edges after rst_s falls.
- RELEASE: counter increments each edge; core i reset falls (i+1)*STAGGER edges after periph_reset falls, in index order 0..N_CORES-1. On the edge core N_CORES-1 releases: ready<=1, FSM<=RUN.
- RUN: all resets low except cores under per-core hold; ready=1.
- soft_req=1 in any state (rst_s low): next edge forces periph_reset=1, core_reset all 1s, ready=0, rst_cause=10, FSM=ASSERT, counter=0, all per-core holds cleared. The sequence restarts from the beginning; a soft_req held high keeps the block in ASSERT with counter 0.
- core_rst_req[i]=1 in RUN: next edge core_reset[i]<=1 and per-core counter loads HOLD_CYCLES. Core reset stays high for exactly HOLD_CYCLES cycles after the request is sampled; it then falls, provided the request has dropped.
  - A re-request during a hold reloads the counter.
  - ready and rst_cause are unaffected.
- core_rst_req ignored outside RUN.
- soft_req has priority over core_rst_req on the same edge.
- rst_cause holds its value until the next pin or soft reset event.
- Pin reset mid-sequence or mid-RUN: immediate async return to the reset state; the sequence restarts from synchroniser release.
- Counter widths: clog2 sized to cover max(HOLD_CYCLES, N_CORES*STAGGER)+1; no wrap is permitted before the terminal count.
- Per-core counter width: clog2(HOLD_CYCLES+1).
- All outputs registered; no combinational path from inputs to outputs except the async reset assertion.

Test Plan:
- POR, defaults (2 cores, HOLD 4, STAGGER 2, SYNC 2): reset rises before edge E0 -> rst_s low at E1; periph_reset falls at E5; core_reset[0] falls at E7; core_reset[1] and ready=1 at E9; rst_cause=01.
- Async assert: drive reset low between edges while in RUN -> periph_reset, core_reset=11 and ready=0 within the same cycle, with no clk edge; release -> full timeline repeats.
- Soft reset in RUN: soft_req pulse for 1 cycle at edge S -> all resets 1 at S; periph_reset falls at S+4; cores fall at S+6 and S+8; rst_cause=10.
- Per-core reset: core_rst_req=01 pulse at edge C in RUN -> core_reset[0] high C..C+3, low at C+4; core_reset[1]=0, ready=1 throughout. Re-pulse at C+2 -> low at C+6.
- Priority/ignore: soft_req and core_rst_req=10 on the same edge -> soft sequence only. core_rst_req during RELEASE -> no effect on the timeline.
- Parameter sweep: N_CORES=4, HOLD=1, STAGGER=1, SYNC=3 -> periph falls 1 edge after rst_s; cores fall at consecutive edges; ready coincident with core 3.
